seven_seg_scanner: RTL and testbench

- Time-multiplexed driver for the 8-digit common-anode seven-segment display.
- Generates the active-low one-hot anode scan sequence (FE, FD, FB, F7, EF, DF, BF, 7F) and the matching active-low cathode pattern for the selected nibble of a double-buffered 32-bit value.
- Sits between the register/CPU side, which loads values and masks, and the board display pins.

---
 rtl/seven_seg_pkg.sv | 15 +
 rtl/seven_seg_scanner_if.sv | 25 ++
 rtl/seven_seg_scanner_hex_to_seg.sv | 11 +
 rtl/seven_seg_scanner.sv | 86 ++++++++
 tb/tb_seven_seg_scanner.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count, idle levels
// and the active-low {g..a} hex segment table.
package seven_seg_pkg;

  localparam int           N_DIGITS  = 8;
  localparam logic [7:0]   ANODE_OFF = 8'hFF;
  localparam logic [6:0]   SEG_OFF   = 7'h7F;

  // Entry 0 is the rightmost element: index with the nibble directly.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seven_seg_scanner_if.sv
// CPU-side load/mask signals and board-side display pins of the scanner.
interface seven_seg_scanner_if;
  import seven_seg_pkg::*;

  logic [31:0]         value_i;
  logic [N_DIGITS-1:0] dp_i;
  logic [N_DIGITS-1:0] enable_i;
  logic                blank_lz_i;
  logic                load_i;
  logic [N_DIGITS-1:0] anode_o;
  logic [6:0]          cathode_o;
  logic                dp_o;
  logic                frame_done_o;

  modport master (
    output value_i, dp_i, enable_i, blank_lz_i, load_i,
    input  anode_o, cathode_o, dp_o, frame_done_o
  );

  modport slave (
    input  value_i, dp_i, enable_i, blank_lz_i, load_i,
    output anode_o, cathode_o, dp_o, frame_done_o
  );

endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational nibble to active-low segment decoder.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed display driver: prescaler, digit index, double-
// buffered value, leading-zero blanking and registered pin outputs.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_scanner_if.slave  bus
);

  localparam int CW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;

  logic [CW-1:0]                cnt;
  logic [2:0]                   idx;
  logic [N_DIGITS-1:0][3:0]     pend, disp;
  logic [N_DIGITS-1:0]          pend_dp, disp_dp;

  logic [N_DIGITS-1:0]          anode_q;
  logic [6:0]                   cathode_q;
  logic                         dp_q, frame_done_q;

  logic                         wrap, xfer, lz_blank, lit;
  logic [N_DIGITS-1:0]          upper_zero;
  logic [N_DIGITS-1:0][6:0]     seg_all;

  assign wrap = (cnt == CW'(DIGIT_PERIOD - 1));
  assign xfer = wrap && (idx == 3'd7);

  // One decoder per digit; the active slot's pattern is picked by idx.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    hex_to_seg u_hex (.nib(disp[g]), .seg(seg_all[g]));
  end

  // upper_zero[i]: nibbles i..7 of the displayed value are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[N_DIGITS-1] = (disp[N_DIGITS-1] == 4'h0);
    for (int i = N_DIGITS - 2; i >= 0; i--)
      upper_zero[i] = upper_zero[i+1] && (disp[i] == 4'h0);
  end

  assign lz_blank = bus.blank_lz_i && (idx != 3'd0) && upper_zero[idx];
  assign lit      = bus.enable_i[idx] && !lz_blank && (cnt >= CW'(BLANK_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      pend         <= '0;
      disp         <= '0;
      pend_dp      <= '0;
      disp_dp      <= '0;
      anode_q      <= ANODE_OFF;
      cathode_q    <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx + 3'd1;

      if (bus.load_i) begin
        pend    <= bus.value_i;
        pend_dp <= bus.dp_i;
      end
      // A load landing on the transfer cycle bypasses the pending buffer.
      if (xfer) begin
        disp    <= bus.load_i ? bus.value_i : pend;
        disp_dp <= bus.load_i ? bus.dp_i    : pend_dp;
      end

      anode_q      <= lit ? ~(N_DIGITS'(1) << idx) : ANODE_OFF;
      cathode_q    <= seg_all[idx];
      dp_q         <= ~disp_dp[idx];
      frame_done_q <= xfer;
    end
  end

  assign bus.anode_o      = anode_q;
  assign bus.cathode_o    = cathode_q;
  assign bus.dp_o         = dp_q;
  assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a 4-cycle slot and 1 blank cycle.
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seven_seg_scanner_if bus();

  seven_seg_scanner #(.DIGIT_PERIOD(4), .BLANK_CYCLES(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 32'(bus.anode_o), 32'h0FF);
    chk({tag, "_ca"}, 32'(bus.cathode_o), 32'h07F);
    chk({tag, "_dp"}, 32'(bus.dp_o), 32'h1);
    chk({tag, "_fd"}, 32'(bus.frame_done_o), 32'h0);
  endtask

  task automatic wait_fd();
    bit got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk);
      if (bus.frame_done_o === 1'b1) got = 1'b1;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL wait_fd: got no pulse expected frame_done_o within 80 cycles");
    end
  endtask

  // Called at the negedge where frame_done_o is high; checks the next 32
  // output cycles (one full frame), optionally pulsing a load at cycle ld_cyc.
  task automatic check_frame(input string name, input logic [7:0][7:0] an,
                             input logic [7:0][6:0] ca, input logic [7:0] dpx,
                             input int ld_cyc, input logic [31:0] ld_val,
                             input logic [7:0] ld_dp);
    for (int j = 0; j < 32; j++) begin
      int s, c;
      s = j / 4;
      c = j % 4;
      @(negedge clk);
      chk($sformatf("%s_an_s%0d_c%0d", name, s, c), 32'(bus.anode_o),
          (c == 0) ? 32'h0FF : 32'(an[s]));
      chk($sformatf("%s_ca_s%0d", name, s), 32'(bus.cathode_o), 32'(ca[s]));
      chk($sformatf("%s_dp_s%0d", name, s), 32'(bus.dp_o), 32'(dpx[s]));
      chk($sformatf("%s_fd_%0d", name, j), 32'(bus.frame_done_o), (j == 31) ? 32'h1 : 32'h0);
      bus.load_i = 1'b0;
      if (j == ld_cyc) begin
        bus.load_i  = 1'b1;
        bus.value_i = ld_val;
        bus.dp_i    = ld_dp;
      end
    end
  endtask

  localparam logic [7:0][7:0] AN_ALL  = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [7:0][7:0] AN_A05  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [7:0][7:0] AN_D0   = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
  localparam logic [7:0][7:0] AN_MASK = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [7:0][6:0] CA_76   = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [7:0][6:0] CA_F    = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h0E};
  localparam logic [7:0][6:0] CA_A05  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12};
  localparam logic [7:0][6:0] CA_ZERO = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [7:0][6:0] CA_89   = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial begin
    rst            = 1'b1;
    bus.value_i    = 32'h0;
    bus.dp_i       = 8'h00;
    bus.enable_i   = 8'hFF;
    bus.blank_lz_i = 1'b0;
    bus.load_i     = 1'b0;

    repeat (20) begin
      @(negedge clk);
      chk_reset("reset_hold");
    end

    rst         = 1'b0;
    bus.load_i  = 1'b1;
    bus.value_i = 32'h76543210;
    @(negedge clk);
    bus.load_i  = 1'b0;
    wait_fd();

    // Full scan order; a mid-frame load at idx 3 must wait for the next frame.
    check_frame("scan", AN_ALL, CA_76, 8'hFF, 11, 32'h0000000F, 8'h00);
    check_frame("midload", AN_ALL, CA_F, 8'hFF, -1, 32'h0, 8'h00);

    // Two loads in one frame: only the second reaches the display.
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (j == 31) chk("twoload_fd", 32'(bus.frame_done_o), 32'h1);
      bus.load_i = 1'b0;
      if (j == 5)  begin bus.load_i = 1'b1; bus.value_i = 32'h11111111; end
      if (j == 20) begin bus.load_i = 1'b1; bus.value_i = 32'h00000A05; end
    end

    bus.blank_lz_i = 1'b1;
    check_frame("lz_a05", AN_A05, CA_A05, 8'hFF, 11, 32'h0, 8'h00);
    // Load on the transfer cycle itself is displayed in the next frame.
    check_frame("lz_zero", AN_D0, CA_ZERO, 8'hFF, 30, 32'h89ABCDEF, 8'h02);

    bus.blank_lz_i = 1'b0;
    bus.enable_i   = 8'h0F;
    check_frame("mask", AN_MASK, CA_89, 8'hFD, -1, 32'h0, 8'h00);
    bus.enable_i   = 8'hFF;

    // Reset at idx 5 with a load pending.
    for (int j = 0; j < 23; j++) begin
      @(negedge clk);
      bus.load_i = 1'b0;
      if (j == 3) begin bus.load_i = 1'b1; bus.value_i = 32'hDEADBEEF; bus.dp_i = 8'hFF; end
      if (j == 22) rst = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      chk_reset("reset_mid");
    end
    rst = 1'b0;
    check_frame("post_rst0", AN_ALL, CA_ZERO, 8'hFF, -1, 32'h0, 8'h00);
    check_frame("post_rst1", AN_ALL, CA_ZERO, 8'hFF, -1, 32'h0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
